decoder_scan_n: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with a valid/ready input handshake.
- Two modes:
  - Direct: decode once and hold the result.
  - Scan: walk the one-hot output from a start index with a programmable dwell per position, wrapping at the top.
- Used as the select generator for row/channel strobing in display and mux fabrics.

---
 rtl/decoder_pkg.sv | 23 ++
 rtl/decoder_onehot.sv | 18 +
 rtl/decoder_scan_n.sv | 140 ++++++++++++++
 tb/tb_decoder_scan_n.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types, mode constants and one-hot helper for decoder_scan_n
package decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest one-hot the helper can describe (IN_W up to 8).
   localparam int ONEHOT_MAX_W = 256;

   // Reference one-hot of an index; out-of-range indices give zero.
   function automatic logic [ONEHOT_MAX_W-1:0] onehot_of(input int unsigned idx);
      logic [ONEHOT_MAX_W-1:0] v;
      v = ONEHOT_MAX_W'(1) << idx;
      return v;
   endfunction

endpackage

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - combinational binary-to-one-hot converter
module decoder_onehot
   import decoder_pkg::*;
#(
   parameter int IN_W = 4
) (
   input  logic [IN_W-1:0]    idx,
   output logic [2**IN_W-1:0] onehot
);

   localparam int OUT_W = 2**IN_W;

   // Single set bit at position idx.
   always_comb begin
      onehot = OUT_W'(1) << idx;
   end

endmodule

// File: rtl/decoder_scan_n.sv
// rtl/decoder_scan_n.sv - registered N-to-2^N one-hot decoder with direct and scan modes (optional DECODER_XPROP_EN)
module decoder_scan_n
   import decoder_pkg::*;
#(
   parameter int IN_W    = 4,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in,
   input  logic [DWELL_W-1:0] dwell,
   output logic [2**IN_W-1:0] out,
   output logic               out_valid,
   output logic [IN_W-1:0]    sel_idx,
   output logic               wrap
);

   localparam int              OUT_W   = 2**IN_W;
   localparam logic [IN_W-1:0] IDX_TOP = {IN_W{1'b1}};

   state_t             state_q;
   state_t             state_d;
   logic [IN_W-1:0]    idx_q;
   logic [IN_W-1:0]    idx_d;
   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_d;
   logic               valid_d;
   logic               wrap_d;
   logic               accept;
   logic [OUT_W-1:0]   onehot_d;

   // Handshake: requests are only taken while not walking.
   always_comb begin
      in_ready = (state_q != SCAN);
      accept   = in_valid & in_ready;
   end

   // Next-state: mode=0 during SCAN wins over any pending request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DIRECT: begin
            if (accept) begin
               state_d = (mode == MODE_SCAN) ? SCAN : DIRECT;
            end
         end
         SCAN: begin
            if (mode == MODE_DIRECT) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: index, dwell counter, valid and wrap pulse.
   always_comb begin
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      valid_d = out_valid;
      wrap_d  = 1'b0;
      case (state_q)
         IDLE, DIRECT: begin
            if (accept) begin
               idx_d   = in;
               valid_d = 1'b1;
               if (mode == MODE_SCAN) begin
                  cnt_d = dwell;
               end
            end
         end
         SCAN: begin
            if (mode == MODE_DIRECT) begin
               idx_d   = '0;
               cnt_d   = '0;
               valid_d = 1'b0;
            end else if (cnt_q == '0) begin
               // Dwell is re-sampled here so mid-scan changes apply from the next position.
               idx_d  = idx_q + IN_W'(1);
               cnt_d  = dwell;
               wrap_d = (idx_q == IDX_TOP);
            end else begin
               cnt_d = cnt_q - DWELL_W'(1);
            end
         end
         default: begin
            idx_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   decoder_onehot #(
      .IN_W (IN_W)
   ) u_onehot (
      .idx    (idx_d),
      .onehot (onehot_d)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Output and counter registers; out is forced to zero whenever not valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         cnt_q     <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         out       <= valid_d ? onehot_d : '0;
         out_valid <= valid_d;
         wrap      <= wrap_d;
`ifdef DECODER_XPROP_EN
         // Simulation-only: an accepted unknown select poisons the outputs until a clean accept.
         if (accept && $isunknown(in)) begin
            idx_q     <= 'x;
            out       <= 'x;
            out_valid <= 1'bx;
         end
`endif
      end
   end

   assign sel_idx = idx_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// tb/tb_decoder_scan_n.sv - randomized self-checking bench for decoder_scan_n against a behavioural model
module tb_decoder_scan_n;
   import decoder_pkg::*;

   localparam int IN_W    = 4;
   localparam int DWELL_W = 8;
   localparam int OUT_W   = 16;

   logic               clk      = 1'b0;
   logic               rst_n    = 1'b0;
   logic               mode     = 1'b0;
   logic               in_valid = 1'b0;
   logic [IN_W-1:0]    in_sel   = '0;
   logic [DWELL_W-1:0] dwell    = '0;
   logic               in_ready;
   logic [OUT_W-1:0]   out;
   logic               out_valid;
   logic [IN_W-1:0]    sel_idx;
   logic               wrap;

   int n_chk = 0;
   int n_err = 0;

   // Model: kind 0 = nothing shown, 1 = holding a decode, 2 = walking.
   int m_kind;
   int m_pos;
   int m_held;
   int m_len;
   bit m_wrap;

   always #5 clk = ~clk;

   decoder_scan_n #(
      .IN_W    (IN_W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_sel),
      .dwell     (dwell),
      .out       (out),
      .out_valid (out_valid),
      .sel_idx   (sel_idx),
      .wrap      (wrap)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_kind = 0;
      m_pos  = 0;
      m_held = 0;
      m_len  = 1;
      m_wrap = 1'b0;
   endtask

   // Position is shown for dwell+1 cycles; the length is fixed when the position is entered.
   task automatic model_edge();
      bit ready;
      ready  = (m_kind != 2);
      m_wrap = 1'b0;
      if (m_kind == 2) begin
         if (mode == MODE_DIRECT) begin
            m_kind = 0;
            m_pos  = 0;
         end else if (m_held >= m_len) begin
            m_pos  = (m_pos + 1) % OUT_W;
            m_held = 1;
            m_len  = int'(dwell) + 1;
            m_wrap = (m_pos == 0);
         end else begin
            m_held++;
         end
      end else if (in_valid && ready) begin
         m_pos = int'(in_sel);
         if (mode == MODE_SCAN) begin
            m_kind = 2;
            m_held = 1;
            m_len  = int'(dwell) + 1;
         end else begin
            m_kind = 1;
         end
      end
   endtask

   task automatic compare();
      logic [ONEHOT_MAX_W-1:0] oh;
      logic [OUT_W-1:0]        e_out;
      oh    = onehot_of(m_pos);
      e_out = (m_kind == 0) ? '0 : oh[OUT_W-1:0];
      chk("out", out, e_out);
      chk("out_valid", out_valid, m_kind != 0);
      chk("wrap", wrap, m_wrap);
      chk("in_ready", in_ready, m_kind != 2);
      if (m_kind != 0) chk("sel_idx", sel_idx, m_pos);
      chk("invariant", (out_valid == (out != '0)) && ($countones(out) <= 1), 1);
   endtask

   task automatic step(input bit m, input bit v, input int i, input int d);
      mode     = m;
      in_valid = v;
      in_sel   = IN_W'(i);
      dwell    = DWELL_W'(d);
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic reset_mid_cycle();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare();
      chk("rst_out", out, 0);
      chk("rst_sel", sel_idx, 0);
      chk("rst_valid", out_valid, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int wraps;
      logic [OUT_W-1:0] scan_exp [8];
      bit               wrap_exp [8];
      scan_exp = '{16'h4000, 16'h4000, 16'h4000, 16'h8000, 16'h8000, 16'h8000, 16'h0001, 16'h0001};
      wrap_exp = '{0, 0, 0, 0, 0, 0, 1, 0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare();
      chk("reset_out", out, 0);
      rst_n = 1'b1;

      // Direct sweep.
      for (int i = 0; i < OUT_W; i++) begin
         step(MODE_DIRECT, 1'b1, i, 0);
         if (i == 0)  chk("sweep_first", out, 16'h0001);
         if (i == 15) chk("sweep_last", out, 16'h8000);
      end
      for (int k = 0; k < 3; k++) step(MODE_DIRECT, 1'b0, int'($urandom_range(0, 15)), 0);
      chk("hold", out, 16'h8000);

      // Async reset during a hold.
      step(MODE_DIRECT, 1'b1, 10, 0);
      chk("direct_a", out, 16'h0400);
      reset_mid_cycle();

      // Scan from 14 with dwell 2 through the wrap.
      for (int k = 0; k < 8; k++) begin
         if (k == 0) step(MODE_SCAN, 1'b1, 14, 2);
         else        step(MODE_SCAN, 1'b0, 0, 2);
         chk("scan_out", out, scan_exp[k]);
         chk("scan_wrap", wrap, wrap_exp[k]);
      end

      // Exit priority, then a normal accept.
      step(MODE_DIRECT, 1'b1, 5, 2);
      chk("exit_out", out, 0);
      step(MODE_DIRECT, 1'b1, 5, 2);
      chk("after_exit", out, 16'h0020);

      // Dwell 3 then switched to 0 mid-hold.
      step(MODE_SCAN, 1'b1, 0, 3);
      step(MODE_SCAN, 1'b0, 0, 3);
      for (int k = 0; k < 2; k++) step(MODE_SCAN, 1'b0, 0, 0);
      chk("dwell_hold", out, 16'h0001);
      step(MODE_SCAN, 1'b0, 0, 0);
      chk("dwell_adv", out, 16'h0002);
      wraps = 0;
      for (int k = 0; k < 16; k++) begin
         step(MODE_SCAN, 1'b0, 0, 0);
         wraps += int'(wrap);
      end
      chk("wrap_count", wraps, 1);
      step(MODE_DIRECT, 1'b0, 0, 0);

`ifdef DECODER_XPROP_EN
      mode     = MODE_DIRECT;
      in_valid = 1'b1;
      in_sel   = 4'bx001;
      @(posedge clk);
      #1;
      chk("xprop_x", out, {OUT_W{1'bx}});
      in_sel = 4'bzzzz;
      @(posedge clk);
      #1;
      chk("xprop_z", out, {OUT_W{1'bx}});
      chk("xprop_valid", out_valid, 1'bx);
      in_sel = 4'h3;
      @(posedge clk);
      #1;
      chk("xprop_clean", out, 16'h0008);
      m_kind = 1;
      m_pos  = 3;
      m_wrap = 1'b0;
`endif

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         bit m;
         if (m_kind == 2) m = ($urandom_range(0, 24) != 0);
         else             m = 1'($urandom_range(0, 1));
         step(m, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 299) == 0) reset_mid_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
